// File: rtl/user_sync_event_capture.sv
// Per-bit debounce filter, edge detector and sticky pending/overflow capture
// for already-synchronized level inputs, with a single OR-ed interrupt request.
module user_sync_event_capture #(
    parameter int                 WIDTH   = 8,
    parameter logic [WIDTH-1:0]   DEFAULT = {WIDTH{1'b0}},
    parameter int                 FILT_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  sync_in,
    input  logic [FILT_W-1:0] filt_len,
    input  logic [WIDTH-1:0]  rise_en,
    input  logic [WIDTH-1:0]  fall_en,
    input  logic [WIDTH-1:0]  clr,
    output logic [WIDTH-1:0]  level_out,
    output logic [WIDTH-1:0]  pend,
    output logic [WIDTH-1:0]  ovf,
    output logic              irq
);

    localparam logic [FILT_W-1:0] CNT_ZERO = {FILT_W{1'b0}};
    localparam logic [FILT_W-1:0] CNT_ONE  = {{(FILT_W-1){1'b0}}, 1'b1};
    localparam logic [FILT_W-1:0] CNT_MAX  = {FILT_W{1'b1}};

    logic [WIDTH-1:0]             s_q, s_d;
    logic [WIDTH-1:0][FILT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]             pend_q, pend_d;
    logic [WIDTH-1:0]             ovf_q, ovf_d;
    logic [WIDTH-1:0]             acc_rise_s, acc_fall_s;
    logic [WIDTH-1:0]             event_s;

    // Stability filter: accept a new level once it has mismatched for more than filt_len edges
    always_comb begin
        s_d        = s_q;
        cnt_d      = cnt_q;
        acc_rise_s = {WIDTH{1'b0}};
        acc_fall_s = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            if (sync_in[i] == s_q[i]) begin
                cnt_d[i] = CNT_ZERO;
            end else if (cnt_q[i] >= filt_len) begin
                // >= lets a lowered filt_len take effect on a count already in flight
                s_d[i]        = sync_in[i];
                cnt_d[i]      = CNT_ZERO;
                acc_rise_s[i] = sync_in[i];
                acc_fall_s[i] = ~sync_in[i];
            end else if (cnt_q[i] != CNT_MAX) begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
    end

    // Event qualification and sticky pend/ovf update; a new event wins over clr
    always_comb begin
        event_s = (acc_rise_s & rise_en) | (acc_fall_s & fall_en);
        pend_d  = event_s | (pend_q & ~clr);
        ovf_d   = (event_s & pend_q) | (ovf_q & ~clr);
    end

    // State registers with asynchronous reset to the synchronizer's default level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q    <= DEFAULT;
            cnt_q  <= {(WIDTH*FILT_W){1'b0}};
            pend_q <= {WIDTH{1'b0}};
            ovf_q  <= {WIDTH{1'b0}};
        end else begin
            s_q    <= s_d;
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
        end
    end

    assign level_out = s_q;
    assign pend      = pend_q;
    assign ovf       = ovf_q;
    assign irq       = |pend_q;

endmodule

// File: tb/tb_user_sync_event_capture.sv
// Bench for user_sync_event_capture: directed vector table, hand sequences for
// mid-count and reset corners, then randomized traffic against a behavioural model.
module tb_user_sync_event_capture;

    localparam int W  = 8;
    localparam int FW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [W-1:0]  sync_in = 8'h00;
    logic [FW-1:0] filt_len = 4'd0;
    logic [W-1:0]  rise_en = 8'h00;
    logic [W-1:0]  fall_en = 8'h00;
    logic [W-1:0]  clr = 8'h00;
    logic [W-1:0]  level_out, pend, ovf;
    logic          irq;
    logic [W-1:0]  ff_level, ff_pend, ff_ovf;
    logic          ff_irq;

    int n_checks = 0;
    int n_fail   = 0;

    // behavioural reference for the DEFAULT=0 instance
    int       run [W];
    bit [W-1:0] m_lvl, m_pend, m_ovf;

    typedef struct {
        logic [W-1:0]  sync;
        logic [FW-1:0] n;
        logic [W-1:0]  ren, fen, clrv;
        logic [W-1:0]  e_lvl, e_pend, e_ovf;
        logic          e_irq;
    } vec_t;
    vec_t tbl[$];

    always #5 clk = ~clk;

    user_sync_event_capture #(.WIDTH(W), .DEFAULT(8'h00), .FILT_W(FW)) dut (
        .clk(clk), .rst_n(rst_n), .sync_in(sync_in), .filt_len(filt_len),
        .rise_en(rise_en), .fall_en(fall_en), .clr(clr),
        .level_out(level_out), .pend(pend), .ovf(ovf), .irq(irq));

    user_sync_event_capture #(.WIDTH(W), .DEFAULT(8'hFF), .FILT_W(FW)) dut_ff (
        .clk(clk), .rst_n(rst_n), .sync_in(sync_in), .filt_len(filt_len),
        .rise_en(rise_en), .fall_en(fall_en), .clr(clr),
        .level_out(ff_level), .pend(ff_pend), .ovf(ff_ovf), .irq(ff_irq));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < W; i++) run[i] = 0;
        m_lvl  = '0;
        m_pend = '0;
        m_ovf  = '0;
    endtask

    // A bit is accepted once it has differed on more than N consecutive edges
    task automatic model_step();
        bit [W-1:0] ev;
        ev = '0;
        for (int i = 0; i < W; i++) begin
            if (sync_in[i] != m_lvl[i]) begin
                if (run[i] >= int'(filt_len)) begin
                    m_lvl[i] = sync_in[i];
                    run[i]   = 0;
                    ev[i]    = sync_in[i] ? rise_en[i] : fall_en[i];
                end else begin
                    run[i] = run[i] + 1;
                end
            end else begin
                run[i] = 0;
            end
        end
        m_ovf  = (ev & m_pend) | (m_ovf & ~bit'(0) & ~clr);
        m_pend = ev | (m_pend & ~clr);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic add(input logic [W-1:0] s, input logic [FW-1:0] n, input logic [W-1:0] re,
                       input logic [W-1:0] fe, input logic [W-1:0] c, input logic [W-1:0] el,
                       input logic [W-1:0] ep, input logic [W-1:0] eo, input logic ei);
        vec_t v;
        v.sync = s; v.n = n; v.ren = re; v.fen = fe; v.clrv = c;
        v.e_lvl = el; v.e_pend = ep; v.e_ovf = eo; v.e_irq = ei;
        tbl.push_back(v);
    endtask

    task automatic check_model(input string tag);
        check({tag, "_level"}, level_out, m_lvl);
        check({tag, "_pend"},  pend,      m_pend);
        check({tag, "_ovf"},   ovf,       m_ovf);
        check({tag, "_irq"},   irq,       |m_pend);
    endtask

    initial begin
        // glitch of 3 at N=3 rejected, then 4-stable high accepted on the 4th edge
        add(8'h01, 4'd3, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        add(8'h01, 4'd3, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        add(8'h01, 4'd3, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        add(8'h00, 4'd3, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        add(8'h00, 4'd3, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        add(8'h01, 4'd3, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        add(8'h01, 4'd3, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        add(8'h01, 4'd3, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        add(8'h01, 4'd3, 8'h01, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 1'b1);
        add(8'h01, 4'd3, 8'h01, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 1'b0);
        // N=0, bit 2 fall-only
        add(8'h05, 4'd0, 8'h00, 8'h04, 8'h00, 8'h05, 8'h00, 8'h00, 1'b0);
        add(8'h01, 4'd0, 8'h00, 8'h04, 8'h00, 8'h01, 8'h04, 8'h00, 1'b1);
        add(8'h01, 4'd0, 8'h00, 8'h04, 8'h04, 8'h01, 8'h00, 8'h00, 1'b0);
        // clear/set collision on bit 1
        add(8'h03, 4'd0, 8'h02, 8'h06, 8'h00, 8'h03, 8'h02, 8'h00, 1'b1);
        add(8'h01, 4'd0, 8'h02, 8'h06, 8'h02, 8'h01, 8'h02, 8'h02, 1'b1);
        add(8'h01, 4'd0, 8'h02, 8'h06, 8'h02, 8'h01, 8'h00, 8'h00, 1'b0);

        model_reset();
        #12;
        check("rst_level", level_out, 8'h00);
        check("rst_pend",  pend,      8'h00);
        check("rst_ovf",   ovf,       8'h00);
        check("rst_irq",   irq,       1'b0);
        check("rst_ff_level", ff_level, 8'hFF);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < tbl.size(); k++) begin
            sync_in = tbl[k].sync; filt_len = tbl[k].n; rise_en = tbl[k].ren;
            fall_en = tbl[k].fen;  clr = tbl[k].clrv;
            tick();
            check($sformatf("vec%0d_level", k), level_out, tbl[k].e_lvl);
            check($sformatf("vec%0d_pend", k),  pend,      tbl[k].e_pend);
            check($sformatf("vec%0d_ovf", k),   ovf,       tbl[k].e_ovf);
            check($sformatf("vec%0d_irq", k),   irq,       tbl[k].e_irq);
        end
        clr = 8'h00;

        // mid-count decrease of filt_len: 3 mismatches at N=7, then N=2 accepts
        filt_len = 4'd7; rise_en = 8'h08; fall_en = 8'h00; sync_in = 8'h09;
        tick(); tick(); tick();
        check("midcnt_hold_level", level_out, 8'h01);
        filt_len = 4'd2;
        tick();
        check("midcnt_acc_level", level_out, 8'h09);
        check("midcnt_acc_pend",  pend,      8'h08);
        check("midcnt_acc_irq",   irq,       1'b1);
        clr = 8'h08;
        tick();
        check("midcnt_clr_pend", pend, 8'h00);
        clr = 8'h00;

        // build pend=A5, ovf=01 and an in-flight count, then reset asynchronously
        filt_len = 4'd0; rise_en = 8'hFF; fall_en = 8'hFF; clr = 8'hFF;
        tick();
        clr = 8'h00; sync_in = 8'hAC;
        tick();
        check("pre_rst_pend_a5", pend, 8'hA5);
        sync_in = 8'hAD;
        tick();
        check("pre_rst_ovf", ovf, 8'h01);
        filt_len = 4'd7; sync_in = 8'hAF;
        tick();
        check("pre_rst_level", level_out, 8'hAD);
        check("pre_rst_pend",  pend,      8'hA5);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("async_rst_level", level_out, 8'h00);
        check("async_rst_pend",  pend,      8'h00);
        check("async_rst_ovf",   ovf,       8'h00);
        check("async_rst_irq",   irq,       1'b0);
        check("async_rst_ff_level", ff_level, 8'hFF);
        check("async_rst_ff_pend",  ff_pend,  8'h00);
        sync_in = 8'h00; filt_len = 4'd1; rise_en = 8'h00; fall_en = 8'hFF;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("rel1_ff_pend",  ff_pend,  8'h00);
        check("rel1_ff_level", ff_level, 8'hFF);
        tick();
        check("rel2_ff_pend",  ff_pend,  8'hFF);
        check("rel2_ff_level", ff_level, 8'h00);
        check("rel2_ff_irq",   ff_irq,   1'b1);
        check("rel2_ff_ovf",   ff_ovf,   8'h00);
        check_model("rel2");

        // randomized per-bit toggles, clears, enable and length changes
        rise_en = 8'hFF; filt_len = 4'd2;
        for (int c = 0; c < 10000; c++) begin
            sync_in = sync_in ^ W'($urandom & $urandom & $urandom);
            clr     = W'($urandom & $urandom & $urandom & $urandom);
            if ($urandom_range(0, 63) == 0) filt_len = FW'($urandom_range(0, 5));
            if ($urandom_range(0, 31) == 0) rise_en = W'($urandom);
            if ($urandom_range(0, 31) == 0) fall_en = W'($urandom);
            tick();
            check_model($sformatf("rnd%0d", c));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
